w5300_reg_conf_sequencer: RTL and testbench
===========================================

Name: w5300_reg_conf_sequencer

Overview:
Parametrised successor to the W5300 common-register config LUT. Walks an external combinational config LUT (index -> {op, addr, value}) and drives each entry as a bus transaction to the W5300 host-bus interface. Adds read-verify and poll-until-match ops, an end-of-table marker, an ack timeout and error reporting. Sits between the init controller and the W5300 bus master.

Parameters:
IDX_W, 6, LUT index width; table depth = 2**IDX_W
ADDR_W, 10, W5300 register address width
DATA_W, 16, register data width
POLL_MAX, 1000, poll retries before error (>=1)
ACK_TIMEOUT, 255, cycles waiting for bus_ack before error (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin table walk (sampled in IDLE/DONE/ERR)
abort  in  1  stop walk, return to IDLE
lut_index  out  IDX_W  index presented to LUT
lut_data  in  2+ADDR_W+DATA_W  {op[1:0], addr, value}, combinational from lut_index
bus_req  out  1  transaction request, held until ack
bus_we  out  1  1=write, 0=read
bus_addr  out  ADDR_W  register address
bus_wdata  out  DATA_W  write data
bus_ack  in  1  one-cycle transaction complete
bus_rdata  in  DATA_W  read data, valid with bus_ack
busy  out  1  walk in progress
done  out  1  walk completed, level until next start
error  out  1  walk failed, level until next start
err_code  out  2  01 verify mismatch, 10 poll exhausted, 11 ack timeout
err_index  out  IDX_W  index of failing entry

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Ops (shared pkg): 00 WRITE, 01 READ_VERIFY, 10 POLL (read until rdata==value), 11 END.
- States: IDLE, FETCH, ISSUE, WAIT_ACK, CHECK, DONE, ERR.
- IDLE/DONE/ERR + start=1 -> FETCH next cycle; lut_index<=0, done/error/err_code/err_index cleared, busy<=1.
- FETCH: register lut_data into entry regs. op END -> DONE (busy<=0, done<=1); else -> ISSUE.
- ISSUE: bus_req<=1, bus_we=(op==WRITE), bus_addr/bus_wdata from entry; -> WAIT_ACK. Fields stable while bus_req=1.
- WAIT_ACK: bus_ack=1 -> bus_req<=0, capture rdata, -> CHECK. Timeout counter increments each cycle without ack; reaching ACK_TIMEOUT -> ERR code 11, bus_req<=0.
- CHECK: WRITE -> advance. READ_VERIFY: rdata==value -> advance, else ERR code 01. POLL: match -> advance and clear poll count; mismatch -> poll count+1; count==POLL_MAX -> ERR code 10, else ISSUE.
- Advance: lut_index==2**IDX_W-1 -> DONE (implicit end, no wrap); else lut_index+1 -> FETCH.
- Write entry minimum latency: FETCH, ISSUE, WAIT_ACK(ack cycle), CHECK = 4 cycles with immediate ack.
- ERR: busy<=0, error<=1, err_index<=lut_index; sticky until start.
- abort: honoured in FETCH/ISSUE/CHECK -> IDLE immediately, busy<=0, done/error unchanged. In WAIT_ACK abort is latched; acted on after ack or timeout (bus transaction never cut short). Timeout during pending abort still reports code 11.
- start while busy ignored. start and abort same cycle in IDLE: abort wins.
- Reset mid-walk: immediate return to reset values, bus_req drops asynchronously.

Decomposition:
- Package w5300_pkg: op codes, err codes, state enum, entry field offsets (OP_LSB = ADDR_W+DATA_W).
- No sub-module; LUT stays external so tables are swappable per register group. Counters inline.

Test Plan:
- Table {W 0x000=0x8000, W 0x008=0x0000, END}, ack 1 cycle later -> two writes in order with those addr/data, done=1, busy=0, error=0.
- READ_VERIFY 0x0FE expect 0x5300, bus_rdata=0x5300 -> advance; second run bus_rdata=0x5301 -> error=1, err_code=01, err_index=entry index.
- POLL 0x002 expect 0x0001, POLL_MAX=4, rdata 0 x3 then 1 -> 4 reads, advance; rdata always 0 -> exactly 4 reads, err_code=10.
- ACK_TIMEOUT=8, bus_ack never -> bus_req high 8 cycles then low, err_code=11, busy=0.
- abort asserted during WAIT_ACK, ack 3 cycles later -> bus_req held until ack, then IDLE, done=0, error=0.
- IDX_W=2, no END in 4 entries -> 4 transactions, lut_index stops at 3, done=1; rst mid-walk -> all outputs 0 next edge.

Source files
------------

// File: rtl/w5300_reg_conf_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// w5300_pkg
//
// Shared definitions for the W5300 register configuration sequencer and for
// the external config LUTs that feed it.
//
//   - Entry op codes carried in the top two bits of each LUT entry.
//   - Error codes reported on err_code.
//   - Sequencer FSM state encodings (exported on the fsm_state debug port).
//   - Helper that gives the bit offset of the op field inside an entry, so
//     LUT authors and the sequencer agree on {op, addr, value} packing.
// ---------------------------------------------------------------------------
package w5300_pkg;

    // Entry operations
    localparam logic [1:0] OP_WRITE       = 2'b00;
    localparam logic [1:0] OP_READ_VERIFY = 2'b01;
    localparam logic [1:0] OP_POLL        = 2'b10;  // read until rdata == value
    localparam logic [1:0] OP_END         = 2'b11;  // end-of-table marker

    // Error codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_VERIFY  = 2'b01;
    localparam logic [1:0] ERR_POLL    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // FSM states
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_FETCH    = 3'd1;
    localparam state_t ST_ISSUE    = 3'd2;
    localparam state_t ST_WAIT_ACK = 3'd3;
    localparam state_t ST_CHECK    = 3'd4;
    localparam state_t ST_DONE     = 3'd5;
    localparam state_t ST_ERR      = 3'd6;

    // Entry layout: {op[1:0], addr[ADDR_W-1:0], value[DATA_W-1:0]}.
    // The value field starts at bit 0 and the addr field at bit DATA_W.
    function automatic int op_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/w5300_reg_conf_sequencer.sv
// ---------------------------------------------------------------------------
// w5300_reg_conf_sequencer
//
// Walks an external combinational config LUT (lut_index -> {op, addr, value})
// and turns each entry into a W5300 host-bus transaction. Supports plain
// writes, read-and-verify, poll-until-match and an end-of-table marker, with
// an ack timeout and sticky error reporting.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a table walk (accepted in IDLE/DONE/ERR only)
//   abort         stop the walk and return to IDLE (deferred while a bus
//                 transaction is outstanding)
//   lut_index     entry index presented to the LUT
//   lut_data      {op, addr, value} for lut_index, combinational
//   bus_req       transaction request, held until bus_ack
//   bus_we        1 = write, 0 = read
//   bus_addr      register address
//   bus_wdata     write data (also carries the compare value on reads)
//   bus_ack       one-cycle transaction complete
//   bus_rdata     read data, valid with bus_ack
//   busy          walk in progress
//   done          walk completed (level until next start)
//   error         walk failed (level until next start)
//   err_code      01 verify mismatch, 10 poll exhausted, 11 ack timeout
//   err_index     index of the failing entry
//   fsm_state     current FSM state, for debug/observation
//
// Bus handshake: bus_req rises with bus_we/bus_addr/bus_wdata valid and all
// four stay constant until the cycle in which bus_ack is sampled high; the
// request drops on the following edge. A transaction is only abandoned by
// the ack timeout or by reset, never by abort.
// ---------------------------------------------------------------------------
module w5300_reg_conf_sequencer
    import w5300_pkg::*;
#(
    parameter int IDX_W       = 6,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int POLL_MAX    = 1000,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic [IDX_W-1:0]           lut_index,
    input  logic [2+ADDR_W+DATA_W-1:0] lut_data,
    output logic                       bus_req,
    output logic                       bus_we,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic                       bus_ack,
    input  logic [DATA_W-1:0]          bus_rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [IDX_W-1:0]           err_index,
    output state_t                     fsm_state
);

    localparam int OP_LSB = op_lsb(ADDR_W, DATA_W);
    localparam int POLL_W = $clog2(POLL_MAX + 1);
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]  IDX_LAST  = '1;

    state_t state;

    // Registered copy of the current entry; the LUT output is only looked
    // at in FETCH so the bus fields cannot move under an open request.
    logic [1:0]        entry_op;
    logic [ADDR_W-1:0] entry_addr;
    logic [DATA_W-1:0] entry_value;

    logic [DATA_W-1:0] rdata_q;
    logic [POLL_W-1:0] poll_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              abort_pend;

    // LUT field split
    logic [1:0]        lut_op;
    logic [ADDR_W-1:0] lut_addr;
    logic [DATA_W-1:0] lut_value;

    assign lut_op    = lut_data[OP_LSB +: 2];
    assign lut_addr  = lut_data[DATA_W +: ADDR_W];
    assign lut_value = lut_data[0 +: DATA_W];

    logic [POLL_W-1:0] poll_next;
    logic [TO_W-1:0]   to_next;
    logic              rdata_match;
    logic              at_last;

    assign poll_next   = poll_cnt + 1'b1;
    assign to_next     = to_cnt + 1'b1;
    assign rdata_match = (rdata_q == entry_value);
    assign at_last     = (lut_index == IDX_LAST);

    assign fsm_state = state;

    // Outcome of the CHECK state for the current entry
    logic       chk_fail;
    logic       chk_retry;
    logic [1:0] chk_code;

    always_comb begin
        chk_fail  = 1'b0;
        chk_retry = 1'b0;
        chk_code  = ERR_NONE;
        case (entry_op)
            OP_READ_VERIFY: begin
                if (!rdata_match) begin
                    chk_fail = 1'b1;
                    chk_code = ERR_VERIFY;
                end
            end
            OP_POLL: begin
                if (!rdata_match) begin
                    // poll_next counts the read just completed
                    if (poll_next == POLL_LAST) begin
                        chk_fail = 1'b1;
                        chk_code = ERR_POLL;
                    end else begin
                        chk_retry = 1'b1;
                    end
                end
            end
            default: begin
                // OP_WRITE always advances; OP_END never reaches CHECK
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lut_index   <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            err_index   <= '0;
            entry_op    <= OP_WRITE;
            entry_addr  <= '0;
            entry_value <= '0;
            rdata_q     <= '0;
            poll_cnt    <= '0;
            to_cnt      <= '0;
            abort_pend  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    // abort takes priority over a coincident start
                    if (start && !abort) begin
                        state      <= ST_FETCH;
                        lut_index  <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_code   <= ERR_NONE;
                        err_index  <= '0;
                        abort_pend <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        entry_op    <= lut_op;
                        entry_addr  <= lut_addr;
                        entry_value <= lut_value;
                        poll_cnt    <= '0;
                        if (lut_op == OP_END) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= (entry_op == OP_WRITE);
                        bus_addr  <= entry_addr;
                        bus_wdata <= entry_value;
                        to_cnt    <= '0;
                        state     <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        rdata_q <= bus_rdata;
                        if (abort_pend || abort) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            abort_pend <= 1'b0;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end else begin
                        // abort waits for the transaction to close
                        if (abort) begin
                            abort_pend <= 1'b1;
                        end
                        if (to_next == TO_LAST) begin
                            // timeout is reported even with an abort pending
                            bus_req    <= 1'b0;
                            abort_pend <= 1'b0;
                            state      <= ST_ERR;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                            err_code   <= ERR_TIMEOUT;
                            err_index  <= lut_index;
                        end else begin
                            to_cnt <= to_next;
                        end
                    end
                end

                ST_CHECK: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (chk_fail) begin
                        state     <= ST_ERR;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_code  <= chk_code;
                        err_index <= lut_index;
                    end else if (chk_retry) begin
                        poll_cnt <= poll_next;
                        state    <= ST_ISSUE;
                    end else begin
                        poll_cnt <= '0;
                        // last table slot is an implicit end; no wrap
                        if (at_last) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            lut_index <= lut_index + 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_reg_conf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_w5300_reg_conf_sequencer
//
// Table-driven bench for the W5300 config sequencer. A small bus responder
// acknowledges requests after a programmable delay, returns scripted read
// data and logs every completed transaction; the log is compared against a
// hand-written expected transaction list per vector.
// ---------------------------------------------------------------------------
module tb_w5300_reg_conf_sequencer;
    import w5300_pkg::*;

    localparam int IDX_W       = 2;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 16;
    localparam int POLL_MAX    = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int ENT_W       = 2 + ADDR_W + DATA_W;
    localparam int TXN_W       = 1 + ADDR_W + DATA_W;
    localparam int N_VEC       = 7;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                start;
    logic                abort;
    logic [IDX_W-1:0]    lut_index;
    logic [ENT_W-1:0]    lut_data;
    logic                bus_req;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_ack = 1'b0;
    logic [DATA_W-1:0]   bus_rdata = '0;
    logic                busy;
    logic                done;
    logic                error;
    logic [1:0]          err_code;
    logic [IDX_W-1:0]    err_index;
    state_t              fsm_state;

    logic [ENT_W-1:0] lut_mem [4];
    assign lut_data = lut_mem[lut_index];

    w5300_reg_conf_sequencer #(
        .IDX_W      (IDX_W),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .POLL_MAX   (POLL_MAX),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .lut_index(lut_index),
        .lut_data (lut_data),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .err_index(err_index),
        .fsm_state(fsm_state)
    );

    // ---------------------------------------------------------------- bus responder
    bit                ack_enable = 1'b1;
    int                ack_delay  = 0;
    int                wait_cnt   = 0;
    int                rd_cnt     = 0;
    int                bad_n      = 0;
    logic [DATA_W-1:0] bad_val    = '0;
    logic [DATA_W-1:0] good_val   = '0;
    logic [TXN_W-1:0]  act_q[$];
    logic [TXN_W-1:0]  exp_q[$];

    // Reads return bad_val for the first bad_n reads of a run, then good_val.
    always @(negedge clk) begin
        if (rst) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else if (bus_ack) begin
            bus_ack = 1'b0;
        end else if (bus_req && ack_enable) begin
            if (wait_cnt >= ack_delay) begin
                bus_ack  = 1'b1;
                wait_cnt = 0;
                act_q.push_back({bus_we, bus_addr, bus_wdata});
                if (!bus_we) begin
                    bus_rdata = (rd_cnt < bad_n) ? bad_val : good_val;
                    rd_cnt++;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [ENT_W-1:0] ent(input logic [1:0] op, input logic [9:0] a,
                                             input logic [15:0] v);
        return {op, a, v};
    endfunction

    function automatic logic [TXN_W-1:0] tx(input logic we, input logic [9:0] a,
                                            input logic [15:0] v);
        return {we, a, v};
    endfunction

    // ---------------------------------------------------------------- driver tasks
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        int c = 0;
        while (busy && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        timed_out = busy;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct packed {
        logic [3:0][ENT_W-1:0] lut;
        logic [7:0]            ack_delay;
        logic [7:0]            bad_n;
        logic [15:0]           bad_val;
        logic [15:0]           good_val;
        logic                  exp_done;
        logic                  exp_error;
        logic [1:0]            exp_code;
        logic [1:0]            exp_eidx;
        logic [1:0]            exp_lidx;
        logic [3:0]            exp_n;
        logic [7:0][TXN_W-1:0] exp_txn;
    } vec_t;

    vec_t vecs [N_VEC];

    task automatic run_vec(input int v);
        vec_t t;
        bit   to;
        t = vecs[v];
        for (int i = 0; i < 4; i++) lut_mem[i] = t.lut[i];
        ack_enable = 1'b1;
        ack_delay  = int'(t.ack_delay);
        bad_n      = int'(t.bad_n);
        bad_val    = t.bad_val;
        good_val   = t.good_val;
        rd_cnt     = 0;
        act_q.delete();
        exp_q.delete();
        for (int i = 0; i < int'(t.exp_n); i++) exp_q.push_back(t.exp_txn[i]);

        pulse_start();
        check($sformatf("v%0d busy after start", v), 32'(busy), 32'd1);
        wait_idle(200, to);
        check($sformatf("v%0d finish in budget", v), 32'(to), 32'd0);
        check($sformatf("v%0d done", v), 32'(done), 32'(t.exp_done));
        check($sformatf("v%0d error", v), 32'(error), 32'(t.exp_error));
        check($sformatf("v%0d err_code", v), 32'(err_code), 32'(t.exp_code));
        check($sformatf("v%0d err_index", v), 32'(err_index), 32'(t.exp_eidx));
        check($sformatf("v%0d lut_index", v), 32'(lut_index), 32'(t.exp_lidx));
        check($sformatf("v%0d bus_req idle", v), 32'(bus_req), 32'd0);
        check($sformatf("v%0d txn count", v), 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; exp_q.size() > 0 && act_q.size() > 0; i++)
            check($sformatf("v%0d txn %0d", v, i), 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main test
    initial begin
        bit to;
        int c;
        int req_cycles;

        // Writes in order, ack one cycle late, explicit END
        vecs[0] = '0;
        vecs[0].lut[0] = ent(OP_WRITE, 10'h000, 16'h8000);
        vecs[0].lut[1] = ent(OP_WRITE, 10'h008, 16'h0000);
        vecs[0].lut[2] = ent(OP_END,   10'h000, 16'h0000);
        vecs[0].lut[3] = ent(OP_END,   10'h000, 16'h0000);
        vecs[0].ack_delay = 8'd1;
        vecs[0].exp_done = 1'b1; vecs[0].exp_lidx = 2'd2; vecs[0].exp_n = 4'd2;
        vecs[0].exp_txn[0] = tx(1'b1, 10'h000, 16'h8000);
        vecs[0].exp_txn[1] = tx(1'b1, 10'h008, 16'h0000);

        // Read-verify match
        vecs[1] = '0;
        vecs[1].lut[0] = ent(OP_WRITE,       10'h010, 16'h1234);
        vecs[1].lut[1] = ent(OP_READ_VERIFY, 10'h0FE, 16'h5300);
        vecs[1].lut[2] = ent(OP_END,         10'h000, 16'h0000);
        vecs[1].lut[3] = ent(OP_END,         10'h000, 16'h0000);
        vecs[1].good_val = 16'h5300;
        vecs[1].exp_done = 1'b1; vecs[1].exp_lidx = 2'd2; vecs[1].exp_n = 4'd2;
        vecs[1].exp_txn[0] = tx(1'b1, 10'h010, 16'h1234);
        vecs[1].exp_txn[1] = tx(1'b0, 10'h0FE, 16'h5300);

        // Read-verify mismatch at entry 1
        vecs[2] = vecs[1];
        vecs[2].good_val = 16'h5301;
        vecs[2].exp_done = 1'b0; vecs[2].exp_error = 1'b1; vecs[2].exp_code = ERR_VERIFY;
        vecs[2].exp_eidx = 2'd1; vecs[2].exp_lidx = 2'd1;

        // Poll: three misses then a match -> 4 reads
        vecs[3] = '0;
        vecs[3].lut[0] = ent(OP_POLL, 10'h002, 16'h0001);
        vecs[3].lut[1] = ent(OP_END,  10'h000, 16'h0000);
        vecs[3].lut[2] = ent(OP_END,  10'h000, 16'h0000);
        vecs[3].lut[3] = ent(OP_END,  10'h000, 16'h0000);
        vecs[3].bad_n = 8'd3; vecs[3].bad_val = 16'h0000; vecs[3].good_val = 16'h0001;
        vecs[3].exp_done = 1'b1; vecs[3].exp_lidx = 2'd1; vecs[3].exp_n = 4'd4;
        for (int i = 0; i < 4; i++) vecs[3].exp_txn[i] = tx(1'b0, 10'h002, 16'h0001);

        // Poll never matches -> exactly POLL_MAX reads, poll error
        vecs[4] = vecs[3];
        vecs[4].bad_n = 8'd99;
        vecs[4].exp_done = 1'b0; vecs[4].exp_error = 1'b1; vecs[4].exp_code = ERR_POLL;
        vecs[4].exp_eidx = 2'd0; vecs[4].exp_lidx = 2'd0;

        // No END marker: walk stops at last slot
        vecs[5] = '0;
        vecs[5].lut[0] = ent(OP_WRITE, 10'h100, 16'h0001);
        vecs[5].lut[1] = ent(OP_WRITE, 10'h101, 16'h0002);
        vecs[5].lut[2] = ent(OP_WRITE, 10'h102, 16'h0003);
        vecs[5].lut[3] = ent(OP_WRITE, 10'h103, 16'h0004);
        vecs[5].ack_delay = 8'd2;
        vecs[5].exp_done = 1'b1; vecs[5].exp_lidx = 2'd3; vecs[5].exp_n = 4'd4;
        vecs[5].exp_txn[0] = tx(1'b1, 10'h100, 16'h0001);
        vecs[5].exp_txn[1] = tx(1'b1, 10'h101, 16'h0002);
        vecs[5].exp_txn[2] = tx(1'b1, 10'h102, 16'h0003);
        vecs[5].exp_txn[3] = tx(1'b1, 10'h103, 16'h0004);

        // Mixed: write, poll with one miss, write, END
        vecs[6] = '0;
        vecs[6].lut[0] = ent(OP_WRITE, 10'h3FF, 16'hFFFF);
        vecs[6].lut[1] = ent(OP_POLL,  10'h004, 16'hA5A5);
        vecs[6].lut[2] = ent(OP_WRITE, 10'h005, 16'h0000);
        vecs[6].lut[3] = ent(OP_END,   10'h000, 16'h0000);
        vecs[6].bad_n = 8'd1; vecs[6].bad_val = 16'h0000; vecs[6].good_val = 16'hA5A5;
        vecs[6].exp_done = 1'b1; vecs[6].exp_lidx = 2'd3; vecs[6].exp_n = 4'd4;
        vecs[6].exp_txn[0] = tx(1'b1, 10'h3FF, 16'hFFFF);
        vecs[6].exp_txn[1] = tx(1'b0, 10'h004, 16'hA5A5);
        vecs[6].exp_txn[2] = tx(1'b0, 10'h004, 16'hA5A5);
        vecs[6].exp_txn[3] = tx(1'b1, 10'h005, 16'h0000);

        for (int i = 0; i < 4; i++) lut_mem[i] = '0;
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset err_code", 32'(err_code), 32'd0);
        check("reset err_index", 32'(err_index), 32'd0);
        check("reset lut_index", 32'(lut_index), 32'd0);
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset bus_addr", 32'(bus_addr), 32'd0);
        check("reset bus_wdata", 32'(bus_wdata), 32'd0);
        check("reset state", 32'(fsm_state), 32'(ST_IDLE));

        for (int v = 0; v < N_VEC; v++) run_vec(v);

        // Ack timeout: request held ACK_TIMEOUT cycles then dropped
        lut_mem[0] = ent(OP_READ_VERIFY, 10'h0FE, 16'h5300);
        lut_mem[1] = ent(OP_END, 10'h000, 16'h0000);
        ack_enable = 1'b0;
        pulse_start();
        req_cycles = 0;
        c = 0;
        while (busy && c < 100) begin
            if (bus_req) req_cycles++;
            @(negedge clk);
            c++;
        end
        check("timeout finish in budget", 32'(busy), 32'd0);
        check("timeout req cycles", 32'(req_cycles), 32'(ACK_TIMEOUT));
        check("timeout bus_req low", 32'(bus_req), 32'd0);
        check("timeout error", 32'(error), 32'd1);
        check("timeout err_code", 32'(err_code), 32'(ERR_TIMEOUT));
        check("timeout err_index", 32'(err_index), 32'd0);
        check("timeout done", 32'(done), 32'd0);
        ack_enable = 1'b1;

        // Abort during WAIT_ACK: request held until ack, then IDLE
        lut_mem[0] = ent(OP_WRITE, 10'h020, 16'h00AA);
        lut_mem[1] = ent(OP_WRITE, 10'h021, 16'h00BB);
        lut_mem[2] = ent(OP_END, 10'h000, 16'h0000);
        lut_mem[3] = ent(OP_END, 10'h000, 16'h0000);
        ack_delay = 3;
        act_q.delete();
        pulse_start();
        c = 0;
        while (!bus_req && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("abort req seen", 32'(bus_req), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort req held 1", 32'(bus_req), 32'd1);
        @(negedge clk);
        check("abort req held 2", 32'(bus_req), 32'd1);
        wait_idle(50, to);
        check("abort finish in budget", 32'(to), 32'd0);
        check("abort state idle", 32'(fsm_state), 32'(ST_IDLE));
        check("abort done", 32'(done), 32'd0);
        check("abort error", 32'(error), 32'd0);
        check("abort bus_req", 32'(bus_req), 32'd0);
        check("abort txn count", 32'(act_q.size()), 32'd1);
        if (act_q.size() > 0)
            check("abort txn 0", 32'(act_q.pop_front()), 32'(tx(1'b1, 10'h020, 16'h00AA)));
        repeat (3) @(negedge clk);
        check("abort no further req", 32'(bus_req), 32'd0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", 32'(busy), 32'd0);
        check("start+abort state", 32'(fsm_state), 32'(ST_IDLE));

        // Reset mid-walk: outputs return to zero asynchronously
        lut_mem[0] = ent(OP_WRITE, 10'h100, 16'h0001);
        lut_mem[1] = ent(OP_WRITE, 10'h101, 16'h0002);
        lut_mem[2] = ent(OP_WRITE, 10'h102, 16'h0003);
        lut_mem[3] = ent(OP_WRITE, 10'h103, 16'h0004);
        ack_delay = 2;
        pulse_start();
        c = 0;
        while (!(bus_req && lut_index == 2'd1) && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("midwalk req seen", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midwalk rst bus_req", 32'(bus_req), 32'd0);
        check("midwalk rst busy", 32'(busy), 32'd0);
        check("midwalk rst lut_index", 32'(lut_index), 32'd0);
        check("midwalk rst bus_addr", 32'(bus_addr), 32'd0);
        check("midwalk rst state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post rst busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
